vm_coin_feeder: RTL and testbench
=================================

// Module: vm_coin_feeder
// PURPOSE
//   Customer-side initiator for vending_machine: takes one purchase request (item + coin budget), drives
//   coin1/coin2 pulses and item into the machine, then waits for deliver_tea/deliver_coffee/change.
//   Used as the bus-functional driver in system benches and as the front end of the kiosk wrapper.
// PARAMETERS
//   TEA_PRICE     2   price of tea in units (coin1 = 1 unit, coin2 = 2 units); 1..7
//   COFFEE_PRICE  3   price of coffee in units; 1..7
//   COIN_GAP      2   idle cycles between consecutive coin pulses; 0..15
//   TIMEOUT       16  cycles to wait for delivery after last coin; 1..255
// PORTS
//   clk              in   1  system clock, rising edge
//   rst              in   1  asynchronous, active-high reset
//   start            in   1  1-cycle request strobe; ignored unless busy=0
//   sel_item         in   1  1 = tea, 0 = coffee; sampled with start
//   ones_avail       in   4  coin1 coins in budget; sampled with start
//   twos_avail       in   4  coin2 coins in budget; sampled with start
//   tea_available    in   2  stock from machine
//   coffee_available in   2  stock from machine
//   deliver_tea      in   1  machine delivery pulse
//   deliver_coffee   in   1  machine delivery pulse
//   change           in   1  machine change pulse
//   coin1            out  1  1-unit coin pulse to machine
//   coin2            out  1  2-unit coin pulse to machine
//   item             out  1  item select to machine
//   busy             out  1  transaction in progress
//   done             out  1  1-cycle completion pulse
//   result           out  2  00 OK, 01 SOLD_OUT, 10 NO_FUNDS, 11 TIMEOUT; valid with done, held until next start
//   got_change       out  1  change seen during this transaction; valid with done
//   coins_used       out  5  units inserted this transaction; valid with done
// BEHAVIOUR
//   Reset: all outputs 0, FSM IDLE; rst mid-transaction aborts immediately, no done pulse.
//   All outputs registered. coin1 and coin2 never high together; each pulse is exactly 1 cycle.
//   item: loaded from sel_item at start, held stable until the cycle after done.
//   FSM: IDLE -> CHECK -> (INSERT <-> GAP)* -> WAIT_DLV -> FINISH -> IDLE.
//   IDLE: start=1 captures sel_item, budgets; busy=1 next cycle. start while busy ignored.
//   CHECK (1 cycle): price = sel ? TEA_PRICE : COFFEE_PRICE.
//     - selected stock == 0 -> FINISH, result SOLD_OUT, no coins.
//     - 2*twos + ones < price -> FINISH, result NO_FUNDS, no coins.
//     - else remaining <= price -> INSERT.
//   INSERT (1 cycle, one pulse): remaining>=2 and twos>0 -> coin2; else ones>0 -> coin1;
//     else coin2 (overpay by 1, change expected). Decrement that budget, remaining saturates at 0,
//     coins_used += 1 or 2. remaining==0 -> WAIT_DLV, else GAP (COIN_GAP cycles; 0 = back-to-back).
//   WAIT_DLV: counter from 0; deliver pulse of the selected item -> FINISH, result OK.
//     Wrong-item delivery ignored. Counter reaching TIMEOUT -> FINISH, result TIMEOUT.
//   got_change: set by any change=1 from INSERT through FINISH; cleared on start. Same-cycle
//     change and deliver both honoured.
//   FINISH (1 cycle): done=1, busy drops with done; new start accepted the following cycle.
//   Stock re-sampled only in CHECK; stock dropping mid-transaction does not abort.
// TESTING
//   1 Tea, price 2, ones=0 twos=1, deliver_tea 3 cycles after coin -> one coin2 pulse, done, result=00, coins_used=2, got_change=0.
//   2 Coffee, price 3, ones=1 twos=1, COIN_GAP=2 -> coin2 then coin1 exactly 3 cycles apart, item=0 held, result=00, coins_used=3.
//   3 Coffee, ones=0 twos=2, change pulse with deliver_coffee -> two coin2 pulses, coins_used=4, got_change=1.
//   4 Tea with tea_available=0 -> done 2 cycles after start, result=01, no coin pulses; ones=1 twos=0 coffee -> result=10.
//   5 No delivery -> done exactly TIMEOUT cycles after last coin, result=11; rst asserted mid-GAP -> all outputs 0 at once, no done.
//   6 start re-pulsed while busy and during FINISH -> ignored; start the cycle after done -> accepted, got_change cleared.

Source files
------------

// File: rtl/vm_coin_feeder.sv
// Customer-side purchase driver for vending_machine: pays for one item with
// coin1/coin2 pulses from a captured budget, then waits for delivery or timeout.
module vm_coin_feeder #(
    parameter int TEA_PRICE    = 2,
    parameter int COFFEE_PRICE = 3,
    parameter int COIN_GAP     = 2,
    parameter int TIMEOUT      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       sel_item,
    input  logic [3:0] ones_avail,
    input  logic [3:0] twos_avail,
    input  logic [1:0] tea_available,
    input  logic [1:0] coffee_available,
    input  logic       deliver_tea,
    input  logic       deliver_coffee,
    input  logic       change,
    output logic       coin1,
    output logic       coin2,
    output logic       item,
    output logic       busy,
    output logic       done,
    output logic [1:0] result,
    output logic       got_change,
    output logic [4:0] coins_used
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        INSERT,
        GAP,
        WAIT_DLV,
        FINISH
    } state_t;

    localparam logic [1:0] RES_OK       = 2'b00;
    localparam logic [1:0] RES_SOLD_OUT = 2'b01;
    localparam logic [1:0] RES_NO_FUNDS = 2'b10;
    localparam logic [1:0] RES_TIMEOUT  = 2'b11;

    localparam logic [2:0] TEA_P    = 3'(TEA_PRICE);
    localparam logic [2:0] COFFEE_P = 3'(COFFEE_PRICE);
    localparam logic [3:0] GAP_LAST = 4'(COIN_GAP - 1);
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

    state_t     state, state_nxt;

    logic       coin1_nxt, coin2_nxt, item_nxt, busy_nxt, done_nxt;
    logic [1:0] result_nxt;
    logic       got_change_nxt;
    logic [4:0] coins_used_nxt;

    logic [3:0] ones_q, twos_q, ones_nxt, twos_nxt;
    logic [2:0] rem_q, rem_nxt;
    logic [3:0] gap_cnt, gap_nxt;
    logic [7:0] wait_cnt, wait_nxt;

    logic       go_insert;
    logic       pick_two;
    logic       dlv_hit;
    logic       stock_zero;
    logic [5:0] funds;

    assign funds      = {1'b0, twos_q, 1'b0} + {2'b00, ones_q};
    // Overpay with a coin2 only when no coin1 is left to settle the last unit.
    assign pick_two   = ((rem_q >= 3'd2) && (twos_q != 4'd0)) || (ones_q == 4'd0);
    assign dlv_hit    = item ? deliver_tea : deliver_coffee;
    assign stock_zero = item ? (tea_available == 2'd0) : (coffee_available == 2'd0);

    always_comb begin
        state_nxt      = state;
        coin1_nxt      = 1'b0;
        coin2_nxt      = 1'b0;
        item_nxt       = item;
        busy_nxt       = busy;
        done_nxt       = 1'b0;
        result_nxt     = result;
        got_change_nxt = got_change;
        coins_used_nxt = coins_used;
        ones_nxt       = ones_q;
        twos_nxt       = twos_q;
        rem_nxt        = rem_q;
        gap_nxt        = gap_cnt;
        wait_nxt       = wait_cnt;
        go_insert      = 1'b0;

        if (change && (state inside {INSERT, GAP, WAIT_DLV, FINISH}))
            got_change_nxt = 1'b1;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt      = CHECK;
                    busy_nxt       = 1'b1;
                    item_nxt       = sel_item;
                    ones_nxt       = ones_avail;
                    twos_nxt       = twos_avail;
                    rem_nxt        = sel_item ? TEA_P : COFFEE_P;
                    result_nxt     = RES_OK;
                    got_change_nxt = 1'b0;
                    coins_used_nxt = 5'd0;
                end
            end
            CHECK: begin
                if (stock_zero) begin
                    state_nxt  = FINISH;
                    done_nxt   = 1'b1;
                    result_nxt = RES_SOLD_OUT;
                end else if (funds < {3'b000, rem_q}) begin
                    state_nxt  = FINISH;
                    done_nxt   = 1'b1;
                    result_nxt = RES_NO_FUNDS;
                end else begin
                    go_insert = 1'b1;
                end
            end
            INSERT: begin
                if (rem_q == 3'd0) begin
                    if (TIMEOUT == 1) begin
                        state_nxt  = FINISH;
                        done_nxt   = 1'b1;
                        result_nxt = RES_TIMEOUT;
                    end else begin
                        state_nxt = WAIT_DLV;
                        // Counts cycles since the last coin pulse.
                        wait_nxt  = 8'd1;
                    end
                end else if (COIN_GAP == 0) begin
                    go_insert = 1'b1;
                end else begin
                    state_nxt = GAP;
                    gap_nxt   = 4'd0;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST)
                    go_insert = 1'b1;
                else
                    gap_nxt = gap_cnt + 4'd1;
            end
            WAIT_DLV: begin
                if (dlv_hit) begin
                    state_nxt  = FINISH;
                    done_nxt   = 1'b1;
                    result_nxt = RES_OK;
                end else if (wait_cnt == TO_LAST) begin
                    state_nxt  = FINISH;
                    done_nxt   = 1'b1;
                    result_nxt = RES_TIMEOUT;
                end else begin
                    wait_nxt = wait_cnt + 8'd1;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase

        // The coin is chosen one cycle early so the pulse lines up with INSERT.
        if (go_insert) begin
            state_nxt = INSERT;
            if (pick_two) begin
                coin2_nxt      = 1'b1;
                twos_nxt       = twos_q - 4'd1;
                rem_nxt        = (rem_q > 3'd2) ? (rem_q - 3'd2) : 3'd0;
                coins_used_nxt = coins_used + 5'd2;
            end else begin
                coin1_nxt      = 1'b1;
                ones_nxt       = ones_q - 4'd1;
                rem_nxt        = rem_q - 3'd1;
                coins_used_nxt = coins_used + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            coin1      <= 1'b0;
            coin2      <= 1'b0;
            item       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= 2'b00;
            got_change <= 1'b0;
            coins_used <= 5'd0;
        end else begin
            state      <= state_nxt;
            coin1      <= coin1_nxt;
            coin2      <= coin2_nxt;
            item       <= item_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            result     <= result_nxt;
            got_change <= got_change_nxt;
            coins_used <= coins_used_nxt;
        end
    end

    // Budget and counters are always loaded before use, so they carry no reset.
    always_ff @(posedge clk) begin
        ones_q   <= ones_nxt;
        twos_q   <= twos_nxt;
        rem_q    <= rem_nxt;
        gap_cnt  <= gap_nxt;
        wait_cnt <= wait_nxt;
    end

endmodule

// File: tb/tb_vm_coin_feeder.sv
// Randomized bench for vm_coin_feeder against a cycle-timeline purchase model.
module tb_vm_coin_feeder;

    localparam int TEA_PRICE    = 2;
    localparam int COFFEE_PRICE = 3;
    localparam int COIN_GAP     = 2;
    localparam int TIMEOUT      = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, sel_item;
    logic [3:0] ones_avail, twos_avail;
    logic [1:0] tea_available, coffee_available;
    logic       deliver_tea, deliver_coffee, change;
    logic       coin1, coin2, item, busy, done, got_change;
    logic [1:0] result;
    logic [4:0] coins_used;

    int total = 0;
    int bad   = 0;

    vm_coin_feeder #(
        .TEA_PRICE(TEA_PRICE),
        .COFFEE_PRICE(COFFEE_PRICE),
        .COIN_GAP(COIN_GAP),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .sel_item(sel_item),
        .ones_avail(ones_avail),
        .twos_avail(twos_avail),
        .tea_available(tea_available),
        .coffee_available(coffee_available),
        .deliver_tea(deliver_tea),
        .deliver_coffee(deliver_coffee),
        .change(change),
        .coin1(coin1),
        .coin2(coin2),
        .item(item),
        .busy(busy),
        .done(done),
        .result(result),
        .got_change(got_change),
        .coins_used(coins_used)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive_idle();
        start = 1'b0; sel_item = 1'b0; ones_avail = 4'd0; twos_avail = 4'd0;
        deliver_tea = 1'b0; deliver_coffee = 1'b0; change = 1'b0;
        tea_available = 2'd3; coffee_available = 2'd3;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_coin1"}, 32'(coin1), 0);
        check_val({tag, "_coin2"}, 32'(coin2), 0);
        check_val({tag, "_item"}, 32'(item), 0);
        check_val({tag, "_busy"}, 32'(busy), 0);
        check_val({tag, "_done"}, 32'(done), 0);
        check_val({tag, "_result"}, 32'(result), 0);
        check_val({tag, "_got_change"}, 32'(got_change), 0);
        check_val({tag, "_coins_used"}, 32'(coins_used), 0);
    endtask

    task automatic idle_cycles(input int n);
        drive_idle();
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check_val("idle_busy", 32'(busy), 0);
            check_val("idle_done", 32'(done), 0);
            check_val("idle_coin", 32'({coin1, coin2}), 0);
        end
    endtask

    // Cycle 0 = start high; the model lays out the whole transaction as a
    // timeline of expected coin pulses and the done cycle before driving it.
    // dly: 0 = never deliver, else delivery this many cycles after the last coin.
    // chg_mode: 0 none, 1 during CHECK (not counted), 2 with delivery, 3 random in window.
    task automatic run_txn(input bit sel, input int ones, input int twos,
                           input int tst, input int cst, input int dly,
                           input int chg_mode, input bit noise);
        int exp_c[128];
        int price, stock, funds, rem, o, t, used, res, last, dcyc, dn, k, ch;
        bit exp_got;
        for (int i = 0; i < 128; i++) exp_c[i] = 0;
        price = sel ? TEA_PRICE : COFFEE_PRICE;
        stock = sel ? tst : cst;
        funds = 2 * twos + ones;
        used  = 0;
        last  = 1;
        dcyc  = -1;
        if (stock == 0) begin
            res = 1; dn = 2;
        end else if (funds < price) begin
            res = 2; dn = 2;
        end else begin
            rem = price; o = ones; t = twos; k = 2;
            while (rem > 0) begin
                if (rem >= 2 && t > 0) begin
                    exp_c[k] = 2; t--; rem -= 2; used += 2;
                end else if (o > 0) begin
                    exp_c[k] = 1; o--; rem -= 1; used += 1;
                end else begin
                    exp_c[k] = 2; t--; rem = 0; used += 2;
                end
                last = k;
                k += COIN_GAP + 1;
            end
            if (dly > 0) begin
                dcyc = last + dly; dn = dcyc + 1; res = 0;
            end else begin
                dn = last + TIMEOUT; res = 3;
            end
        end
        case (chg_mode)
            1: ch = 1;
            2: ch = dcyc;
            3: ch = (dn - 1 >= 2) ? int'($urandom_range(2, dn - 1)) : -1;
            default: ch = -1;
        endcase
        exp_got = (ch >= 2) && (ch <= dn - 1);

        for (int c = 0; c <= dn; c++) begin
            check_val("coin1", 32'(coin1), 32'(exp_c[c] == 1));
            check_val("coin2", 32'(coin2), 32'(exp_c[c] == 2));
            check_val("busy", 32'(busy), 32'(c >= 1));
            check_val("done", 32'(done), 32'(c == dn));
            if (c >= 1) check_val("item", 32'(item), 32'(sel));
            if (c == 1) check_val("got_change_cleared", 32'(got_change), 0);
            if (c == dn) begin
                check_val("result", 32'(result), 32'(res));
                check_val("coins_used", 32'(coins_used), 32'(used));
                check_val("got_change", 32'(got_change), 32'(exp_got));
            end
            if (c == 0) begin
                start = 1'b1; sel_item = sel;
                ones_avail = 4'(ones); twos_avail = 4'(twos);
            end else begin
                start = noise && ($urandom_range(0, 3) == 0);
                sel_item = 1'($urandom_range(0, 1));
                ones_avail = 4'($urandom_range(0, 15));
                twos_avail = 4'($urandom_range(0, 15));
            end
            if (c <= 1) begin
                tea_available = 2'(tst); coffee_available = 2'(cst);
            end else if (noise) begin
                tea_available = 2'($urandom_range(0, 3));
                coffee_available = 2'($urandom_range(0, 3));
            end
            deliver_tea    = sel ? (c == dcyc) : (noise && c > last && $urandom_range(0, 3) == 0);
            deliver_coffee = sel ? (noise && c > last && $urandom_range(0, 3) == 0) : (c == dcyc);
            change = (c == ch);
            @(posedge clk); #1;
        end
        start = 1'b0; deliver_tea = 1'b0; deliver_coffee = 1'b0; change = 1'b0;
    endtask

    task automatic reset_mid_gap();
        start = 1'b1; sel_item = 1'b0; ones_avail = 4'd1; twos_avail = 4'd1;
        tea_available = 2'd3; coffee_available = 2'd3;
        deliver_tea = 1'b0; deliver_coffee = 1'b0; change = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check_val("rst_pre_coin2", 32'(coin2), 1);
        @(posedge clk); #1;
        check_val("rst_pre_busy", 32'(busy), 1);
        check_val("rst_pre_gap_coin", 32'({coin1, coin2}), 0);
        #2 rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        idle_cycles(24);
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        idle_cycles(2);

        run_txn(1'b1, 0, 1, 3, 3, 3, 0, 1'b0);
        run_txn(1'b0, 1, 1, 3, 3, 2, 0, 1'b0);
        run_txn(1'b0, 0, 2, 3, 3, 4, 2, 1'b0);
        run_txn(1'b1, 5, 5, 0, 3, 2, 0, 1'b0);
        run_txn(1'b0, 1, 0, 3, 3, 2, 0, 1'b0);
        run_txn(1'b1, 2, 0, 2, 2, 0, 0, 1'b0);
        idle_cycles(3);
        reset_mid_gap();
        run_txn(1'b1, 2, 2, 1, 1, 1, 1, 1'b0);
        run_txn(1'b1, 0, 1, 1, 1, 2, 3, 1'b1);
        run_txn(1'b0, 3, 0, 1, 1, 5, 0, 1'b1);
        run_txn(1'b0, 0, 0, 2, 2, 1, 0, 1'b1);

        for (int n = 0; n < 150; n++) begin
            bit s;
            int on, tw, ts, cs, dl;
            s  = 1'($urandom_range(0, 1));
            on = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
            tw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
            ts = $urandom_range(0, 3);
            cs = $urandom_range(0, 3);
            dl = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, TIMEOUT - 1));
            run_txn(s, on, tw, ts, cs, dl, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 3)));
        end
        idle_cycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
